// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - Shared constants, fetch buffer entry type and helpers for the fetch stage
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fbuf_entry_t;

  // Event counters stick at all-ones rather than wrapping back to a small value.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - Synchronous FIFO with push/pop/flush and an occupancy count
// flush clears the FIFO on the next edge and takes priority over push and pop.
module fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is only legal when a pop frees a slot the same cycle.
  assign do_pop  = pop & (count != '0);
  assign do_push = push & ((count != CW'(DEPTH)) | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_cycle_buffered.sv
// rtl/fetch_cycle_buffered.sv - Fetch stage: in-order imem requests, fetch buffer, IF/ID register
// Define FETCH_PERF_EN to add saturating perf_redirects/perf_dropped/perf_bubbles outputs.
module fetch_cycle_buffered
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned FBUF_DEPTH      = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Stall,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic        PCSrcD,
  input  logic [31:0] PCTargetD,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_redirects,
  output logic [31:0] perf_dropped,
  output logic [31:0] perf_bubbles
`endif
);

  localparam int unsigned IFW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned FBW = $clog2(FBUF_DEPTH + 1);

  logic [31:0]    pcf;
  logic [31:0]    target;
  logic [31:0]    if_head;
  logic [IFW-1:0] if_count;
  logic [IFW-1:0] drop_cnt;
  logic [FBW-1:0] fb_count;
  fbuf_entry_t    fb_in;
  fbuf_entry_t    fb_head;
  logic           redir;
  logic           fb_empty;
  logic           credit_ok;
  logic           req_fire;
  logic           rsp_take;
  logic           rsp_keep;
  logic           fb_pop;

  assign redir  = PCSrcE | (PCSrcD & ~Stall);
  assign target = PCSrcE ? PCTargetE : PCTargetD;

  // Every request in flight owns a buffer slot, so responses can never overflow the buffer.
  assign fb_empty  = (fb_count == '0);
  assign credit_ok = (32'(if_count) < MAX_OUTSTANDING) &&
                     (32'(if_count) + 32'(fb_count) < FBUF_DEPTH);

  assign imem_req_valid = rst & ~redir & credit_ok;
  assign imem_req_addr  = pcf;
  assign req_fire       = imem_req_valid & imem_req_ready;

  // Responses with nothing outstanding (e.g. left over from before a reset) are ignored.
  assign rsp_take = imem_rsp_valid & (if_count != '0);
  assign rsp_keep = rsp_take & (drop_cnt == '0) & ~redir;
  assign fb_pop   = ~redir & ~Stall & ~fb_empty;
  assign fb_in    = '{pc: if_head, instr: imem_rsp_data};

  fetch_fifo #(
    .WIDTH (32),
    .DEPTH (MAX_OUTSTANDING)
  ) u_inflight (
    .clk       (clk),
    .flush     (~rst),
    .push      (req_fire),
    .push_data (pcf),
    .pop       (rsp_take),
    .head      (if_head),
    .count     (if_count)
  );

  fetch_fifo #(
    .WIDTH ($bits(fbuf_entry_t)),
    .DEPTH (FBUF_DEPTH)
  ) u_fbuf (
    .clk       (clk),
    .flush     (~rst | redir),
    .push      (rsp_keep),
    .push_data (fb_in),
    .pop       (fb_pop),
    .head      (fb_head),
    .count     (fb_count)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      pcf      <= RESET_PC;
      drop_cnt <= '0;
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else begin
      if (redir)         pcf <= target;
      else if (req_fire) pcf <= pcf + PC_STEP;

      // Everything still outstanding after this cycle's response is wrong-path.
      if (redir)                          drop_cnt <= if_count - IFW'(rsp_take);
      else if (rsp_take && drop_cnt != '0) drop_cnt <= drop_cnt - IFW'(1);

      if (redir || (!Stall && fb_empty)) begin
        InstrD   <= NOP_INSTR;
        PCD      <= '0;
        PCPlus4D <= '0;
        ValidD   <= 1'b0;
      end else if (!Stall) begin
        InstrD   <= fb_head.instr;
        PCD      <= fb_head.pc;
        PCPlus4D <= fb_head.pc + PC_STEP;
        ValidD   <= 1'b1;
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_redirects <= '0;
      perf_dropped   <= '0;
      perf_bubbles   <= '0;
    end else begin
      if (redir)                 perf_redirects <= sat_inc(perf_redirects);
      if (rsp_take && !rsp_keep) perf_dropped   <= sat_inc(perf_dropped);
      if (!Stall && fb_empty)    perf_bubbles   <= sat_inc(perf_bubbles);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_cycle_buffered.sv
// tb/tb_fetch_cycle_buffered.sv - Self-checking bench for fetch_cycle_buffered with a queue-based model
// Covers FETCH_PERF_EN counters when the macro is defined.
module tb_fetch_cycle_buffered;

  localparam int FBUF_DEPTH = 4;
  localparam int MAX_OUT    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        Stall = 1'b0;
  logic        PCSrcE = 1'b0;
  logic [31:0] PCTargetE = '0;
  logic        PCSrcD = 1'b0;
  logic [31:0] PCTargetD = '0;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_redirects;
  logic [31:0] perf_dropped;
  logic [31:0] perf_bubbles;
`endif

  fetch_cycle_buffered #(
    .RESET_PC        (32'h0000_0000),
    .FBUF_DEPTH      (FBUF_DEPTH),
    .MAX_OUTSTANDING (MAX_OUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .Stall          (Stall),
    .PCSrcE         (PCSrcE),
    .PCTargetE      (PCTargetE),
    .PCSrcD         (PCSrcD),
    .PCTargetD      (PCTargetD),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .InstrD         (InstrD),
    .PCD            (PCD),
    .PCPlus4D       (PCPlus4D),
    .ValidD         (ValidD)
`ifdef FETCH_PERF_EN
    ,
    .perf_redirects (perf_redirects),
    .perf_dropped   (perf_dropped),
    .perf_bubbles   (perf_bubbles)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A3C_0F96;
  endfunction

  // Pipelined in-order memory: each accepted request answers after lat_lo..lat_hi cycles.
  typedef struct {
    int          due;
    logic [31:0] addr;
  } mreq_t;
  mreq_t mq[$];
  int cyc = 0;
  int last_due = 0;
  int lat_lo = 1;
  int lat_hi = 1;

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (mq.size() > 0 && mq[0].due == cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
  end

  // Reference model: queues of outstanding fetches (tagged stale on redirect) and buffered instructions.
  typedef struct {
    logic [31:0] pc;
    bit          stale;
  } inf_t;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } fb_t;
  inf_t        m_inf[$];
  fb_t         m_fb[$];
  logic [31:0] m_pcf, m_instr, m_pcd, m_pc4;
  logic        m_valid;
  bit          m_live = 0;
  int unsigned m_redir_n, m_drop_n, m_bub_n;

  always @(negedge clk) begin
    bit          redir;
    bit          exp_req;
    bit          fb_was_empty;
    logic [31:0] tgt;
    int          due;
    inf_t        e;
    fb_t         h;
    redir   = PCSrcE | (PCSrcD & ~Stall);
    tgt     = PCSrcE ? PCTargetE : PCTargetD;
    exp_req = rst && !redir && (m_inf.size() < MAX_OUT) &&
              (m_inf.size() + m_fb.size() < FBUF_DEPTH);
    if (m_live) begin
      chk("ValidD", ValidD, m_valid);
      chk("InstrD", InstrD, m_instr);
      chk("PCD", PCD, m_pcd);
      chk("PCPlus4D", PCPlus4D, m_pc4);
      chk("req_valid", imem_req_valid, exp_req);
      if (exp_req) chk("req_addr", imem_req_addr, m_pcf);
`ifdef FETCH_PERF_EN
      chk("perf_redirects", perf_redirects, m_redir_n);
      chk("perf_dropped", perf_dropped, m_drop_n);
      chk("perf_bubbles", perf_bubbles, m_bub_n);
`endif
    end
    if (rst && imem_req_valid && imem_req_ready) begin
      due = cyc + int'($urandom_range(lat_hi, lat_lo));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mq.push_back('{due, imem_req_addr});
    end
    if (!rst) begin
      m_inf.delete();
      m_fb.delete();
      m_pcf = 32'h0; m_instr = 32'h0; m_pcd = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      m_redir_n = 0; m_drop_n = 0; m_bub_n = 0;
      m_live = 1;
    end else if (m_live) begin
      fb_was_empty = (m_fb.size() == 0);
      if (!Stall && fb_was_empty) m_bub_n++;
      if (redir) begin
        m_redir_n++;
        m_instr = 0; m_pcd = 0; m_pc4 = 0; m_valid = 0;
      end else if (!Stall) begin
        if (!fb_was_empty) begin
          h = m_fb.pop_front();
          m_instr = h.instr; m_pcd = h.pc; m_pc4 = h.pc + 32'd4; m_valid = 1;
        end else begin
          m_instr = 0; m_pcd = 0; m_pc4 = 0; m_valid = 0;
        end
      end
      if (imem_rsp_valid && m_inf.size() > 0) begin
        e = m_inf.pop_front();
        if (e.stale || redir) m_drop_n++;
        else m_fb.push_back('{e.pc, instr_of(e.pc)});
      end
      if (redir) begin
        m_fb.delete();
        foreach (m_inf[i]) m_inf[i].stale = 1;
        m_pcf = tgt;
      end else if (exp_req && imem_req_ready) begin
        m_inf.push_back('{m_pcf, 1'b0});
        m_pcf = m_pcf + 32'd4;
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 0; Stall = 0; PCSrcE = 0; PCSrcD = 0; imem_req_ready = 1;
    repeat (n) nxt();
    rst = 1;
  endtask

  initial begin
    // Free-run then a 3-cycle stall while PCD=0x8.
    lat_lo = 1; lat_hi = 1;
    do_reset(6);
    for (int k = 0; k < 13; k++) begin
      Stall = (k >= 5 && k <= 7);
      @(negedge clk);
      case (k)
        0: begin
          chk("lit reset ValidD", ValidD, 0);
          chk("lit reset PCD", PCD, 0);
          chk("lit reset InstrD", InstrD, 0);
          chk("lit first addr", imem_req_addr, 32'h0);
          chk("lit first req", imem_req_valid, 1);
        end
        2: chk("lit c2 ValidD", ValidD, 0);
        3: begin
          chk("lit c3 ValidD", ValidD, 1);
          chk("lit c3 PCD", PCD, 32'h0);
          chk("lit c3 PCPlus4D", PCPlus4D, 32'h4);
        end
        4: chk("lit c4 PCD", PCD, 32'h4);
        5: chk("lit c5 PCD", PCD, 32'h8);
        6, 7, 8: chk("lit stall hold PCD", PCD, 32'h8);
        9: chk("lit release PCD", PCD, 32'hC);
        10: chk("lit release PCD+1", PCD, 32'h10);
        11: chk("lit release PCD+2", PCD, 32'h14);
        default: ;
      endcase
      if (k == 7 || k == 8) chk("lit credit stop", imem_req_valid, 0);
      nxt();
    end

    // Execute redirect with two requests in flight (3-cycle memory).
    lat_lo = 3; lat_hi = 3;
    do_reset(6);
    for (int k = 0; k < 11; k++) begin
      PCSrcE = (k == 2); PCTargetE = 32'h100;
      @(negedge clk);
      if (k == 3) chk("lit redirE addr", imem_req_addr, 32'h100);
      if (k >= 3 && k <= 8) chk("lit redirE bubble", ValidD, 0);
      if (k == 9) begin
        chk("lit redirE ValidD", ValidD, 1);
        chk("lit redirE PCD", PCD, 32'h100);
`ifdef FETCH_PERF_EN
        chk("lit perf_redirects", perf_redirects, 1);
        chk("lit perf_dropped", perf_dropped, 2);
`endif
      end
      nxt();
    end

    // PCSrcE beats PCSrcD; PCSrcD ignored under Stall.
    lat_lo = 1; lat_hi = 1;
    do_reset(6);
    PCSrcE = 1; PCTargetE = 32'h200; PCSrcD = 1; PCTargetD = 32'h40;
    @(negedge clk); chk("lit both redir req", imem_req_valid, 0);
    nxt();
    PCSrcE = 0; PCSrcD = 1; PCTargetD = 32'h80; Stall = 1;
    @(negedge clk); chk("lit E wins addr", imem_req_addr, 32'h200);
    nxt();
    PCSrcD = 0; Stall = 0;
    @(negedge clk); chk("lit D ignored addr", imem_req_addr, 32'h204);
    nxt();

    // Ready toggling across the address wrap.
    do_reset(6);
    for (int k = 0; k < 14; k++) begin
      PCSrcE = (k == 0); PCTargetE = 32'hFFFF_FFF0;
      imem_req_ready = (k == 0) || (k % 2 == 1);
      @(negedge clk);
      case (k)
        1: chk("lit wrap addr0", imem_req_addr, 32'hFFFF_FFF0);
        2: chk("lit wrap hold", imem_req_addr, 32'hFFFF_FFF4);
        7: chk("lit wrap addrFC", imem_req_addr, 32'hFFFF_FFFC);
        8: chk("lit wrap to 0", imem_req_addr, 32'h0);
        10: begin
          chk("lit wrap PCD", PCD, 32'hFFFF_FFFC);
          chk("lit wrap PCPlus4D", PCPlus4D, 32'h0);
        end
        12: chk("lit wrap PCD0", PCD, 32'h0);
        default: ;
      endcase
      nxt();
    end

    // Randomized traffic with variable latency, stalls, redirects and occasional reset.
    lat_lo = 1; lat_hi = 3;
    do_reset(6);
    for (int k = 0; k < 4000; k++) begin
      if (rst && $urandom_range(199) == 0) begin
        do_reset(6);
      end
      Stall          = ($urandom_range(99) < 30);
      PCSrcE         = ($urandom_range(99) < 5);
      PCSrcD         = ($urandom_range(99) < 8);
      PCTargetE      = $urandom & 32'hFFFF_FFFC;
      PCTargetD      = $urandom & 32'hFFFF_FFFC;
      imem_req_ready = ($urandom_range(99) < 75);
      @(negedge clk);
      nxt();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
